pulse_seq_bank: RTL and testbench

//  Parametrised bank of CHANNELS pulse sequencers with a shared operate gate.

---
 rtl/pulse_seq_bank.sv | 232 +++++++++++++++++++++++
 tb/tb_pulse_seq_bank.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_seq_bank.sv
// -----------------------------------------------------------------------------
// pulse_seq_bank
//   Bank of CHANNELS independent pulse sequencers sharing one run gate.
//   Each channel is programmed over a byte-wide command bus and, while the
//   gate is open, runs:
//     DELAY -> ACTIVE -> INACTIVE -> ACTIVE ...   (continuous mode)
//     DELAY -> ACTIVE -> DONE                     (one-shot mode)
//   When stopped or disabled, a channel's output rests at its idle level.
//
// Parameters
//   CHANNELS  number of sequencer channels (1..64)
//   COUNT_W   period counter width, multiple of 8 (8..64)
//
// Ports
//   clk      design clock
//   reset_n  asynchronous active-low reset
//   operate  run gate; its rising edge starts all enabled channels
//   cmd_rdy  command byte valid; a byte is consumed on every edge it is high
//   cmd      command byte (header, then little-endian payload)
//   cmd_ack  byte consumed this cycle (always ready, so equals cmd_rdy)
//   out      registered sequencer outputs, one per channel
//   running  channel is in DELAY, ACTIVE or INACTIVE
// -----------------------------------------------------------------------------
module pulse_seq_bank #(
   parameter int CHANNELS = 4,
   parameter int COUNT_W  = 32
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                operate,
   input  logic                cmd_rdy,
   input  logic [7:0]          cmd,
   output logic                cmd_ack,
   output logic [CHANNELS-1:0] out,
   output logic [CHANNELS-1:0] running
);

   localparam int NBYTES = COUNT_W / 8;

   typedef enum logic [1:0] {
      REG_CTRL  = 2'd0,
      REG_DELAY = 2'd1,
      REG_HIGH  = 2'd2,
      REG_LOW   = 2'd3
   } reg_sel_e;

   typedef enum logic {
      P_HEADER,
      P_PAYLOAD
   } parse_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DELAY,
      S_ACTIVE,
      S_INACTIVE,
      S_DONE
   } seq_e;

   // ---------------------------------------------------------------------------
   // Command parser and per-channel configuration registers
   // ---------------------------------------------------------------------------
   parse_e               parse_q;
   reg_sel_e             sel_q;
   logic [5:0]           chan_q;
   logic [3:0]           byte_q;
   logic [COUNT_W-1:0]   stage_q;
   logic [COUNT_W-1:0]   stage_next;
   logic                 last_byte;

   logic [CHANNELS-1:0]  en_q;
   logic [CHANNELS-1:0]  idle_q;
   logic [CHANNELS-1:0]  one_q;
   logic [COUNT_W-1:0]   delay_q [CHANNELS];
   logic [COUNT_W-1:0]   high_q  [CHANNELS];
   logic [COUNT_W-1:0]   low_q   [CHANNELS];

   logic                 operate_q;
   logic                 t0;

   assign cmd_ack = cmd_rdy;
   assign t0      = operate & ~operate_q;

   // Staging value including the byte on the bus, so the final byte commits
   // in the same edge that accepts it.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      stage_next                = stage_q;
      stage_next[8*byte_q +: 8] = cmd;
      last_byte                 = (sel_q == REG_CTRL) || (byte_q == 4'(NBYTES - 1));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         parse_q   <= P_HEADER;
         sel_q     <= REG_CTRL;
         chan_q    <= '0;
         byte_q    <= '0;
         stage_q   <= '0;
         operate_q <= 1'b0;
         en_q      <= '0;
         idle_q    <= '0;
         one_q     <= '0;
         // NOTE: the configuration arrays are flops, not RAM, and must read as
         // zero after reset, so every entry is cleared here.
         for (int i = 0; i < CHANNELS; i++) begin
            delay_q[i] <= '0;
            high_q[i]  <= '0;
            low_q[i]   <= '0;
         end
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples pre-edge values; this is what makes a phase load on the
         // commit edge see the old register contents.
         operate_q <= operate;
         if (cmd_rdy) begin
            if (parse_q == P_HEADER) begin
               sel_q   <= reg_sel_e'(cmd[7:6]);
               chan_q  <= cmd[5:0];
               byte_q  <= '0;
               parse_q <= P_PAYLOAD;
            end else if (!last_byte) begin
               stage_q <= stage_next;
               byte_q  <= byte_q + 4'd1;
            end else begin
               parse_q <= P_HEADER;
               // Out-of-range channels match no index and are silently dropped.
               for (int i = 0; i < CHANNELS; i++) begin
                  if (chan_q == 6'(i)) begin
                     unique case (sel_q)
                        REG_CTRL: begin
                           en_q[i]   <= cmd[0];
                           idle_q[i] <= cmd[1];
                           one_q[i]  <= cmd[2];
                        end
                        REG_DELAY: delay_q[i] <= stage_next;
                        REG_HIGH:  high_q[i]  <= stage_next;
                        REG_LOW:   low_q[i]   <= stage_next;
                        default:   ;
                     endcase
                  end
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Per-channel sequencers
   // ---------------------------------------------------------------------------
   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      seq_e               state_q;
      logic [COUNT_W-1:0] cnt_q;
      logic               out_q;
      logic [COUNT_W-1:0] high_load;
      logic [COUNT_W-1:0] low_load;

      // A zero period behaves as one cycle: load max(P,1)-1.
      assign high_load = (high_q[g] == '0) ? '0 : high_q[g] - COUNT_W'(1);
      assign low_load  = (low_q[g]  == '0) ? '0 : low_q[g]  - COUNT_W'(1);

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
         end else if (!operate) begin
            state_q <= S_IDLE;
            out_q   <= idle_q[g];
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  out_q <= idle_q[g];
                  if (t0 && en_q[g]) begin
                     state_q <= S_DELAY;
                     cnt_q   <= delay_q[g];
                  end
               end
               S_DELAY: begin
                  if (!en_q[g]) begin
                     state_q <= S_IDLE;
                     out_q   <= idle_q[g];
                  end else if (cnt_q == '0) begin
                     state_q <= S_ACTIVE;
                     out_q   <= ~idle_q[g];
                     cnt_q   <= high_load;
                  end else begin
                     cnt_q <= cnt_q - COUNT_W'(1);
                  end
               end
               S_ACTIVE: begin
                  if (!en_q[g]) begin
                     state_q <= S_IDLE;
                     out_q   <= idle_q[g];
                  end else if (cnt_q == '0) begin
                     state_q <= one_q[g] ? S_DONE : S_INACTIVE;
                     out_q   <= idle_q[g];
                     cnt_q   <= low_load;
                  end else begin
                     cnt_q <= cnt_q - COUNT_W'(1);
                  end
               end
               S_INACTIVE: begin
                  if (!en_q[g]) begin
                     state_q <= S_IDLE;
                     out_q   <= idle_q[g];
                  end else if (cnt_q == '0) begin
                     state_q <= S_ACTIVE;
                     out_q   <= ~idle_q[g];
                     cnt_q   <= high_load;
                  end else begin
                     cnt_q <= cnt_q - COUNT_W'(1);
                  end
               end
               S_DONE: begin
                  out_q <= idle_q[g];
               end
               default: begin
                  state_q <= S_IDLE;
                  out_q   <= idle_q[g];
               end
            endcase
         end
      end

      assign out[g]     = out_q;
      assign running[g] = (state_q == S_DELAY) || (state_q == S_ACTIVE) ||
                          (state_q == S_INACTIVE);
   end

endmodule

// File: tb/tb_pulse_seq_bank.sv
// -----------------------------------------------------------------------------
// tb_pulse_seq_bank
//   Self-checking bench for pulse_seq_bank. Three instances share clock, reset,
//   operate and the command byte; each has its own cmd_rdy:
//     u_main  CHANNELS=4, COUNT_W=32
//     u_small CHANNELS=1, COUNT_W=8
//     u_wide  CHANNELS=8, COUNT_W=64
//   Expected outputs come from a time-based model: cycles elapsed since the
//   start edge are mapped to output levels with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_pulse_seq_bank;

   localparam int NCH = 4;

   logic       clk;
   logic       reset_n;
   logic       operate;
   logic [7:0] cmd;
   logic       rdy_m, rdy_s, rdy_w;
   logic       ack_m, ack_s, ack_w;
   logic [3:0] out_m, run_m;
   logic [0:0] out_s, run_s;
   logic [7:0] out_w, run_w;

   int checks = 0;
   int errors = 0;

   // Register-file model of u_main
   bit     m_en   [NCH];
   bit     m_idle [NCH];
   bit     m_one  [NCH];
   longint m_d    [NCH];
   longint m_h    [NCH];
   longint m_l    [NCH];

   pulse_seq_bank #(.CHANNELS(4), .COUNT_W(32)) u_main (
      .clk(clk), .reset_n(reset_n), .operate(operate), .cmd_rdy(rdy_m),
      .cmd(cmd), .cmd_ack(ack_m), .out(out_m), .running(run_m));

   pulse_seq_bank #(.CHANNELS(1), .COUNT_W(8)) u_small (
      .clk(clk), .reset_n(reset_n), .operate(operate), .cmd_rdy(rdy_s),
      .cmd(cmd), .cmd_ack(ack_s), .out(out_s), .running(run_s));

   pulse_seq_bank #(.CHANNELS(8), .COUNT_W(64)) u_wide (
      .clk(clk), .reset_n(reset_n), .operate(operate), .cmd_rdy(rdy_w),
      .cmd(cmd), .cmd_ack(ack_w), .out(out_w), .running(run_w));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- model ---
   // Is the channel in its active level t cycles after the start edge?
   function automatic bit act_at(longint t, longint d, longint h, longint l, bit one);
      longint hh = (h == 0) ? 1 : h;
      longint ll = (l == 0) ? 1 : l;
      if (t < d + 1) return 1'b0;
      if (one) return (t <= d + hh);
      return ((t - d - 1) % (hh + ll)) < hh;
   endfunction

   function automatic bit run_at(longint t, longint d, longint h, bit one);
      longint hh = (h == 0) ? 1 : h;
      return one ? (t <= d + hh) : 1'b1;
   endfunction

   function automatic logic [3:0] exp_out(longint t);
      logic [3:0] v;
      for (int i = 0; i < NCH; i++)
         v[i] = m_en[i] ? (m_idle[i] ^ act_at(t, m_d[i], m_h[i], m_l[i], m_one[i])) : m_idle[i];
      return v;
   endfunction

   function automatic logic [3:0] exp_run(longint t);
      logic [3:0] v;
      for (int i = 0; i < NCH; i++)
         v[i] = m_en[i] & run_at(t, m_d[i], m_h[i], m_one[i]);
      return v;
   endfunction

   function automatic logic [3:0] idle_vec();
      logic [3:0] v;
      for (int i = 0; i < NCH; i++) v[i] = m_idle[i];
      return v;
   endfunction

   // ------------------------------------------------------------- drivers ---
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input int dut, input logic [7:0] b, output logic ack);
      cmd   = b;
      rdy_m = (dut == 0);
      rdy_s = (dut == 1);
      rdy_w = (dut == 2);
      #1;
      ack = (dut == 0) ? ack_m : (dut == 1) ? ack_s : ack_w;
      @(posedge clk);
      #1;
      rdy_m = 1'b0;
      rdy_s = 1'b0;
      rdy_w = 1'b0;
   endtask

   // Full register write; returns the number of bytes acknowledged.
   task automatic write_reg(input int dut, input int ch, input int sel,
                            input logic [63:0] value, output int acks);
      int   nb;
      logic a;
      nb   = (sel == 0) ? 1 : (dut == 0) ? 4 : (dut == 1) ? 1 : 8;
      acks = 0;
      send_byte(dut, {2'(sel), 6'(ch)}, a);
      acks += int'(a);
      for (int i = 0; i < nb; i++) begin
         send_byte(dut, value[8*i +: 8], a);
         acks += int'(a);
      end
      if (dut == 0 && ch < NCH) begin
         case (sel)
            0: begin
               m_en[ch]   = value[0];
               m_idle[ch] = value[1];
               m_one[ch]  = value[2];
            end
            1: m_d[ch] = longint'(value[31:0]);
            2: m_h[ch] = longint'(value[31:0]);
            default: m_l[ch] = longint'(value[31:0]);
         endcase
      end
   endtask

   task automatic clear_all();
      int n;
      operate = 1'b0;
      for (int c = 0; c < NCH; c++)
         for (int s = 0; s < 4; s++) write_reg(0, c, s, 64'd0, n);
      step();
   endtask

   task automatic start_run();
      operate = 1'b0;
      step();
      operate = 1'b1;
      step();   // start edge has passed: t = 0
   endtask

   task automatic reset_model();
      for (int i = 0; i < NCH; i++) begin
         m_en[i] = 0; m_idle[i] = 0; m_one[i] = 0;
         m_d[i] = 0;  m_h[i] = 0;    m_l[i] = 0;
      end
   endtask

   // --------------------------------------------------------------- tests ---
   task automatic test_reset();
      logic a;
      int   n;
      reset_n = 1'b0;
      operate = 1'b1;
      step();
      checks++;
      if (out_m !== 4'b0 || run_m !== 4'b0 || ack_m !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold out=%b run=%b ack=%b required 0/0/0", out_m, run_m, ack_m);
      end
      reset_n = 1'b1;
      step();
      send_byte(0, 8'h40, a);   // DELAY header for ch0 ...
      checks++;
      if (a !== 1'b1) begin
         errors++;
         $display("FAIL reset_ack got=%b required 1", a);
      end
      send_byte(0, 8'h11, a);
      send_byte(0, 8'h22, a);   // ... abandoned after two payload bytes
      reset_n = 1'b0;
      #1;
      checks++;
      if (out_m !== 4'b0 || run_m !== 4'b0) begin
         errors++;
         $display("FAIL reset_mid out=%b run=%b required 0/0", out_m, run_m);
      end
      reset_model();
      step();
      reset_n = 1'b1;
      operate = 1'b0;
      step();
      write_reg(0, 0, 0, 64'h03, n);   // must be parsed as a fresh CTRL write
      step();
      checks++;
      if (out_m !== 4'b0001 || run_m !== 4'b0) begin
         errors++;
         $display("FAIL reset_first_cmd out=%b run=%b required 0001/0000", out_m, run_m);
      end
   endtask

   task automatic test_basic();
      int n;
      clear_all();
      write_reg(0, 0, 1, 64'd3, n);
      write_reg(0, 0, 2, 64'd2, n);
      write_reg(0, 0, 3, 64'd5, n);
      write_reg(0, 0, 0, 64'h01, n);
      start_run();
      for (int t = 0; t <= 24; t++) begin
         checks++;
         if (out_m !== exp_out(t) || run_m !== exp_run(t)) begin
            errors++;
            $display("FAIL basic t=%0d out=%b run=%b required %b/%b",
                     t, out_m, run_m, exp_out(t), exp_run(t));
         end
         step();
      end
      operate = 1'b0;
      step();
   endtask

   task automatic test_oneshot();
      int n;
      clear_all();
      write_reg(0, 1, 1, 64'd0, n);
      write_reg(0, 1, 2, 64'd4, n);
      write_reg(0, 1, 3, 64'd3, n);
      write_reg(0, 1, 0, 64'h05, n);
      for (int pass = 0; pass < 2; pass++) begin
         start_run();
         for (int t = 0; t <= 14; t++) begin
            checks++;
            if (out_m !== exp_out(t) || run_m !== exp_run(t)) begin
               errors++;
               $display("FAIL oneshot pass=%0d t=%0d out=%b run=%b required %b/%b",
                        pass, t, out_m, run_m, exp_out(t), exp_run(t));
            end
            step();
         end
      end
      operate = 1'b0;
      step();
   endtask

   task automatic test_idle_bad_channel();
      int n;
      clear_all();
      write_reg(0, 2, 1, 64'd1, n);
      write_reg(0, 2, 0, 64'h03, n);           // ch2 idle high, HIGH=LOW=0
      write_reg(0, 1, 1, 64'd2, n);
      write_reg(0, 1, 2, 64'd1, n);
      write_reg(0, 1, 3, 64'd2, n);
      write_reg(0, 1, 0, 64'h01, n);
      write_reg(0, 9, 1, 64'h0707_0707, n);    // out of range: dropped
      checks++;
      if (n !== 5) begin
         errors++;
         $display("FAIL bad_ch_delay_acks got=%0d required 5", n);
      end
      write_reg(0, 9, 0, 64'h00, n);
      checks++;
      if (n !== 2) begin
         errors++;
         $display("FAIL bad_ch_ctrl_acks got=%0d required 2", n);
      end
      step();
      checks++;
      if (out_m !== idle_vec()) begin
         errors++;
         $display("FAIL idle_level out=%b required %b", out_m, idle_vec());
      end
      start_run();
      for (int t = 0; t <= 15; t++) begin
         checks++;
         if (out_m !== exp_out(t) || run_m !== exp_run(t)) begin
            errors++;
            $display("FAIL idle_bad t=%0d out=%b run=%b required %b/%b",
                     t, out_m, run_m, exp_out(t), exp_run(t));
         end
         step();
      end
      operate = 1'b0;
      step();
   endtask

   task automatic test_live_update();
      int         n;
      logic [7:0] bytes [5];
      bit         act;
      logic       eo, er;
      bytes[0] = 8'hC0; bytes[1] = 8'h02; bytes[2] = 8'h00; bytes[3] = 8'h00; bytes[4] = 8'h00;
      clear_all();
      write_reg(0, 0, 2, 64'd2, n);
      write_reg(0, 0, 3, 64'd5, n);
      write_reg(0, 0, 0, 64'h03, n);   // idle high, active low
      start_run();
      for (int t = 0; t <= 20; t++) begin
         // LOW becomes 2 mid-way through the first INACTIVE phase
         act = (t == 1 || t == 2 || t == 8 || t == 9 || (t >= 12 && ((t - 12) % 4) < 2));
         eo  = (t >= 14) ? 1'b1 : ~act;
         er  = (t < 14);
         checks++;
         if (out_m[0] !== eo || run_m[0] !== er) begin
            errors++;
            $display("FAIL live t=%0d out=%b run=%b required %b/%b", t, out_m[0], run_m[0], eo, er);
         end
         if (t >= 3 && t <= 7) begin
            cmd   = bytes[t-3];
            rdy_m = 1'b1;
         end else begin
            rdy_m = 1'b0;
         end
         if (t == 13) operate = 1'b0;
         step();
      end
      m_l[0] = 2;
   endtask

   task automatic test_random();
      int n;
      for (int it = 0; it < 6; it++) begin
         operate = 1'b0;
         for (int c = 0; c < NCH; c++) begin
            write_reg(0, c, 1, 64'($urandom_range(0, 8)), n);
            write_reg(0, c, 2, 64'($urandom_range(0, 5)), n);
            write_reg(0, c, 3, 64'($urandom_range(0, 5)), n);
            write_reg(0, c, 0, 64'($urandom_range(0, 7)), n);
         end
         start_run();
         for (int t = 0; t <= 40; t++) begin
            checks++;
            if (out_m !== exp_out(t) || run_m !== exp_run(t)) begin
               errors++;
               $display("FAIL random it=%0d t=%0d out=%b run=%b required %b/%b",
                        it, t, out_m, run_m, exp_out(t), exp_run(t));
            end
            step();
         end
         operate = 1'b0;
         step();
         checks++;
         if (out_m !== idle_vec() || run_m !== 4'b0) begin
            errors++;
            $display("FAIL random_stop it=%0d out=%b run=%b required %b/0000",
                     it, out_m, run_m, idle_vec());
         end
      end
   endtask

   task automatic test_sweep();
      int         n;
      logic [7:0] ew, rw;
      operate = 1'b0;
      write_reg(1, 0, 1, 64'd2, n);
      checks++;
      if (n !== 2) begin
         errors++;
         $display("FAIL small_acks got=%0d required 2", n);
      end
      write_reg(1, 0, 2, 64'd255, n);    // full-scale HIGH
      write_reg(1, 0, 3, 64'd1, n);
      write_reg(1, 0, 0, 64'h01, n);
      write_reg(1, 1, 2, 64'd5, n);      // out of range for CHANNELS=1
      write_reg(2, 7, 1, 64'h0000_0000_0000_0105, n);
      checks++;
      if (n !== 9) begin
         errors++;
         $display("FAIL wide_acks got=%0d required 9", n);
      end
      write_reg(2, 7, 2, 64'd3, n);
      write_reg(2, 7, 3, 64'd0, n);
      write_reg(2, 7, 0, 64'h01, n);
      start_run();
      for (int t = 0; t <= 270; t++) begin
         checks++;
         if (out_s[0] !== act_at(t, 2, 255, 1, 0) || run_s[0] !== 1'b1) begin
            errors++;
            $display("FAIL small t=%0d out=%b run=%b required %b/1",
                     t, out_s[0], run_s[0], act_at(t, 2, 255, 1, 0));
         end
         ew = {act_at(t, 261, 3, 0, 0), 7'b0};
         rw = 8'h80;
         checks++;
         if (out_w !== ew || run_w !== rw) begin
            errors++;
            $display("FAIL wide t=%0d out=%b run=%b required %b/%b", t, out_w, run_w, ew, rw);
         end
         step();
      end
      operate = 1'b0;
      step();
   endtask

   initial begin
      reset_n = 1'b0;
      operate = 1'b0;
      cmd     = 8'h00;
      rdy_m   = 1'b0;
      rdy_s   = 1'b0;
      rdy_w   = 1'b0;
      reset_model();
      test_reset();
      test_basic();
      test_oneshot();
      test_idle_bad_channel();
      test_live_update();
      test_random();
      test_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
